cpc_mailbox_ctrl: RTL

Synchronous command/response mailbox between the CPC Z80 I/O bus and the ATMega. It sits behind the CPLD's address and mode decode and replaces the edge-clocked data latches with a clocked, handshaken single-entry buffer in each direction. It adds a command-pending flag for the ATMega, a response-valid flag for the CPC, and overrun accounting. The CPC polls a status byte; the ATMega consumes commands with an acknowledge and posts responses with a strobe.

---
 rtl/cpc_mailbox_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/cpc_mailbox_ctrl.sv
// CPC <-> ATMega mailbox: one-entry command buffer toward the ATMega, one-entry
// response buffer toward the CPC, with a pollable status byte and overrun count.
module cpc_mailbox_ctrl (
   input  logic       iCLK,
   input  logic       iRESET,
   input  logic       i_IORQ,
   input  logic       i_RD,
   input  logic       i_WR,
   input  logic       iDATA_HIT,
   input  logic       iSTAT_HIT,
   input  logic [7:0] iCPC_DATA,
   output logic [7:0] oCPC_DATA,
   output logic       oCPC_DATA_OE,
   output logic [7:0] oATMEGA_DATA,
   output logic       oCMD_READY,
   input  logic       iATMEGA_ACK,
   input  logic [7:0] iATMEGA_DATA,
   input  logic       iATMEGA_STB,
   output logic       oOVERRUN
);

   localparam int WR = 0, RDD = 1, RDS = 2, ACK = 3, STB = 4;

   typedef enum logic {EMPTY, FULL} cmd_state_t;

   logic [4:0]       raw;
   logic [4:0][2:0]  sync;
   logic [4:0]       rise, fall;
   cmd_state_t       state, state_nxt;
   logic             load, ovr_evt;
   logic [7:0]       resp;
   logic             resp_valid;
   logic [3:0]       ovr_cnt;
   logic [7:0]       status;

   assign raw[WR]  = ~i_IORQ & ~i_WR & iDATA_HIT;
   assign raw[RDD] = ~i_IORQ & ~i_RD & iDATA_HIT;
   assign raw[RDS] = ~i_IORQ & ~i_RD & iSTAT_HIT;
   assign raw[ACK] = iATMEGA_ACK;
   assign raw[STB] = iATMEGA_STB;

   // Two flops of metastability protection, third flop for edge detection.
   always_ff @(posedge iCLK) begin
      if (iRESET) sync <= '0;
      else
         for (int i = 0; i < 5; i++) sync[i] <= {sync[i][1:0], raw[i]};
   end

   always_comb begin
      for (int i = 0; i < 5; i++) begin
         rise[i] = sync[i][1] & ~sync[i][2];
         fall[i] = ~sync[i][1] & sync[i][2];
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRESET) state <= EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      ovr_evt   = 1'b0;
      case (state)
         EMPTY: if (rise[WR]) begin
            load      = 1'b1;
            state_nxt = FULL;
         end
         FULL: begin
            // A consume and a new write in the same cycle is a clean hand-over.
            if (rise[WR] && rise[ACK]) load = 1'b1;
            else if (rise[ACK])        state_nxt = EMPTY;
            else if (rise[WR])         ovr_evt = 1'b1;
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         oATMEGA_DATA <= '0;
         oOVERRUN     <= 1'b0;
         ovr_cnt      <= '0;
         resp         <= '0;
         resp_valid   <= 1'b0;
      end else begin
         if (load) oATMEGA_DATA <= iCPC_DATA;
         if (ovr_evt) begin
            oOVERRUN <= 1'b1;
            if (ovr_cnt != 4'hF) ovr_cnt <= ovr_cnt + 4'd1;
         end else if (fall[RDS]) begin
            oOVERRUN <= 1'b0;
         end
         if (rise[STB]) begin
            resp       <= iATMEGA_DATA;
            resp_valid <= 1'b1;
         end else if (fall[RDD]) begin
            resp_valid <= 1'b0;
         end
      end
   end

   assign oCMD_READY   = (state == FULL);
   assign status       = {oCMD_READY, resp_valid, oOVERRUN, 1'b0, ovr_cnt};
   // Read path is combinational; clears wait for the fall edge so data holds.
   assign oCPC_DATA_OE = ~i_IORQ & ~i_RD & (iDATA_HIT | iSTAT_HIT);
   assign oCPC_DATA    = iSTAT_HIT ? status : resp;

endmodule
